// File: rtl/trace_buffer_sched.sv
// Arbitrates the single trace_buffer port between the display read path and
// queued ray-tracer column results; tracks per-frame completion and overrun.
module trace_buffer_sched #(
    parameter int COLUMNS       = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h,
    input  logic [9:0] v,
    input  logic       visible,
    output logic       trace_start,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] req_column,
    input  logic [7:0] req_height,
    input  logic       req_side,
    output logic [9:0] mem_addr,
    output logic [8:0] mem_wdata,
    input  logic [8:0] mem_rdata,
    output logic       mem_cs,
    output logic       mem_we,
    output logic       mem_oe,
    output logic [7:0] disp_height,
    output logic       disp_side,
    output logic       frame_done,
    output logic       overrun
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [9:0]    COL_MAX   = 10'(COLUMNS);
    localparam logic [9:0]    COL_LAST  = 10'(COLUMNS - 1);
    localparam logic [9:0]    FS_LINE   = 10'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACING = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Queue entry layout: {column[9:0], side, height[7:0]} so the low 9 bits are the write data.
    logic [18:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    state_e     state_q, state_d;
    logic [9:0] col_cnt_q, col_cnt_d;
    logic       overrun_q, overrun_d;
    logic       trace_start_q;
    logic [7:0] disp_height_q;
    logic       disp_side_q;

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        push_s;
    logic        pop_s;
    logic [18:0] head_s;
    logic [9:0]  head_col_s;
    logic        head_in_range_s;
    logic        wr_s;
    logic        frame_start_s;
    logic        completing_s;
    logic        frame_done_s;

    assign fifo_full_s     = (fifo_cnt_q == DEPTH_C);
    assign fifo_empty_s    = (fifo_cnt_q == {CW{1'b0}});
    assign push_s          = req_valid && !fifo_full_s;
    assign pop_s           = !visible && !fifo_empty_s;
    assign head_s          = fifo_mem_q[rd_ptr_q];
    assign head_col_s      = head_s[18:9];
    assign head_in_range_s = (head_col_s < COL_MAX);
    assign wr_s            = pop_s && head_in_range_s;
    assign frame_start_s   = (v == FS_LINE) && (h == 10'd0);
    assign completing_s    = wr_s && (col_cnt_q == COL_LAST);

    assign req_ready   = !fifo_full_s;
    assign trace_start = trace_start_q;
    assign disp_height = disp_height_q;
    assign disp_side   = disp_side_q;
    assign overrun     = overrun_q;
    assign frame_done  = frame_done_s;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 19'd0;
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            fifo_cnt_q <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= {req_column, req_side, req_height};
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Frame FSM state register, column count and sticky overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            col_cnt_q <= 10'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Frame FSM next-state; a completing write beats a coincident frame start for overrun
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start_s) begin
                    state_d   = ST_TRACING;
                    col_cnt_d = 10'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_TRACING: begin
                if (completing_s) begin
                    if (frame_start_s) begin
                        state_d   = ST_TRACING;
                        col_cnt_d = 10'd0;
                    end else begin
                        state_d   = ST_DONE;
                        col_cnt_d = COL_MAX;
                    end
                end else if (frame_start_s) begin
                    overrun_d = 1'b1;
                    col_cnt_d = 10'd0;
                end else if (wr_s && (col_cnt_q < COL_MAX)) begin
                    col_cnt_d = col_cnt_q + 10'd1;
                end else begin
                    col_cnt_d = col_cnt_q;
                end
            end
            ST_DONE: begin
                if (frame_start_s) begin
                    state_d   = ST_TRACING;
                    col_cnt_d = 10'd0;
                end else begin
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                col_cnt_d = 10'd0;
            end
        endcase
    end

    // Frame FSM outputs
    always_comb begin
        frame_done_s = 1'b0;
        case (state_q)
            ST_TRACING: frame_done_s = completing_s;
            default:    frame_done_s = 1'b0;
        endcase
    end

    // Memory port: display reads win while visible, otherwise drain one queued result
    always_comb begin
        mem_cs    = 1'b1;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        mem_addr  = 10'd0;
        mem_wdata = 9'd0;
        if (visible) begin
            mem_oe   = 1'b1;
            mem_addr = h;
        end else if (!fifo_empty_s) begin
            mem_addr  = head_col_s;
            mem_wdata = head_s[8:0];
            mem_we    = head_in_range_s;
        end else begin
            mem_we = 1'b0;
        end
    end

    // Display data capture and trace-start pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_height_q <= 8'd0;
            disp_side_q   <= 1'b0;
            trace_start_q <= 1'b0;
        end else begin
            if (visible) begin
                disp_height_q <= mem_rdata[7:0];
                disp_side_q   <= mem_rdata[8];
            end else begin
                disp_height_q <= 8'd0;
                disp_side_q   <= 1'b0;
            end
            trace_start_q <= frame_start_s;
        end
    end

endmodule
